// File: rtl/rgb_seq_pwm.sv
// N-channel PWM colour sequencer: writable palette stepped manually or by a
// timer, optional linear crossfade, duty latched only at PWM period boundaries.
module rgb_seq_pwm #(
  parameter int N_CH       = 3,
  parameter int DW         = 8,
  parameter int N_COL      = 7,
  parameter int TICK_DIV   = 1000000,
  parameter int AUTO_STEPS = 100,
  parameter logic [N_COL*N_CH*DW-1:0] PAL_INIT = '0,
  localparam int AW = (N_COL > 1) ? $clog2(N_COL) : 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               mode,
  input  logic               dir,
  input  logic               step,
  input  logic               fade_en,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [N_CH*DW-1:0] wr_data,
  output logic [AW-1:0]      color_idx,
  output logic [N_CH*DW-1:0] level,
  output logic               busy,
  output logic [N_CH-1:0]    pwm_out
);
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (AUTO_STEPS > 1) ? $clog2(AUTO_STEPS) : 1;
  localparam int EW = N_CH * DW;
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] AUTO_LAST = SW'(AUTO_STEPS - 1);
  localparam logic [AW-1:0] IDX_LAST  = AW'(N_COL - 1);
  localparam logic [DW-1:0] PWM_LAST  = {{(DW-1){1'b1}}, 1'b0};
  localparam logic [EW-1:0] ENTRY0    = PAL_INIT[EW-1:0];

  typedef logic [N_CH-1:0][DW-1:0] chan_t;

  // One-LSB move toward the target; never overshoots or wraps.
  function automatic logic [DW-1:0] approach(input logic [DW-1:0] cur,
                                             input logic [DW-1:0] tgt);
    logic [DW-1:0] nxt;
    if (cur < tgt) begin
      nxt = cur + DW'(1);
    end else if (cur > tgt) begin
      nxt = cur - DW'(1);
    end else begin
      nxt = cur;
    end
    return nxt;
  endfunction

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [SW-1:0] auto_cnt_q, auto_cnt_d;
  logic          step_q, step_d;
  logic [AW-1:0] idx_q, idx_d;
  logic [EW-1:0] pal_q [N_COL];
  logic [EW-1:0] pal_d [N_COL];
  chan_t         level_q, level_d;
  chan_t         duty_q, duty_d;
  chan_t         target_s;
  logic          busy_q, busy_d;
  logic [DW-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [N_CH-1:0] pwm_q, pwm_d;
  logic          tick_s, step_edge_s, advance_s;

  // Free-running tick divider.
  always_comb begin
    tick_s = (tick_cnt_q == TICK_LAST);
    if (tick_s) begin
      tick_cnt_d = {TW{1'b0}};
    end else begin
      tick_cnt_d = tick_cnt_q + TW'(1);
    end
  end

  // Advance source: step edge in manual mode, every AUTO_STEPS-th tick in auto.
  always_comb begin
    step_d      = step;
    step_edge_s = step & ~step_q;
    if (!en || !mode) begin
      auto_cnt_d = {SW{1'b0}};
    end else if (tick_s) begin
      auto_cnt_d = (auto_cnt_q == AUTO_LAST) ? {SW{1'b0}} : auto_cnt_q + SW'(1);
    end else begin
      auto_cnt_d = auto_cnt_q;
    end
    advance_s = en & (mode ? (tick_s & (auto_cnt_q == AUTO_LAST)) : step_edge_s);
  end

  // Palette index with wrap in both directions.
  always_comb begin
    if (!advance_s) begin
      idx_d = idx_q;
    end else if (!dir) begin
      idx_d = (idx_q == IDX_LAST) ? {AW{1'b0}} : idx_q + AW'(1);
    end else begin
      idx_d = (idx_q == {AW{1'b0}}) ? IDX_LAST : idx_q - AW'(1);
    end
  end

  // Palette write port; out-of-range addresses are dropped.
  always_comb begin
    pal_d = pal_q;
    if (wr_en && (wr_addr <= IDX_LAST)) begin
      pal_d[wr_addr] = wr_data;
    end else begin
      pal_d = pal_q;
    end
  end

  // Level follows target: snap, or crossfade one LSB per tick.
  always_comb begin
    target_s = pal_q[idx_q];
    busy_d   = (level_q != target_s);
    level_d  = level_q;
    for (int c = 0; c < N_CH; c++) begin
      if (!fade_en) begin
        level_d[c] = target_s[c];
      end else if (tick_s) begin
        level_d[c] = approach(level_q[c], target_s[c]);
      end else begin
        level_d[c] = level_q[c];
      end
    end
  end

  // PWM period counter, boundary duty latch and output compare.
  always_comb begin
    if (pwm_cnt_q == PWM_LAST) begin
      pwm_cnt_d = {DW{1'b0}};
      duty_d    = level_q;
    end else begin
      pwm_cnt_d = pwm_cnt_q + DW'(1);
      duty_d    = duty_q;
    end
    for (int c = 0; c < N_CH; c++) begin
      pwm_d[c] = en & (pwm_cnt_q < duty_q[c]);
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt_q <= {TW{1'b0}};
      auto_cnt_q <= {SW{1'b0}};
      step_q     <= 1'b0;
      idx_q      <= {AW{1'b0}};
      for (int k = 0; k < N_COL; k++) begin
        pal_q[k] <= PAL_INIT[k*EW +: EW];
      end
      level_q    <= ENTRY0;
      duty_q     <= ENTRY0;
      busy_q     <= 1'b0;
      pwm_cnt_q  <= {DW{1'b0}};
      pwm_q      <= {N_CH{1'b0}};
    end else begin
      tick_cnt_q <= tick_cnt_d;
      auto_cnt_q <= auto_cnt_d;
      step_q     <= step_d;
      idx_q      <= idx_d;
      pal_q      <= pal_d;
      level_q    <= level_d;
      duty_q     <= duty_d;
      busy_q     <= busy_d;
      pwm_cnt_q  <= pwm_cnt_d;
      pwm_q      <= pwm_d;
    end
  end

  assign color_idx = idx_q;
  assign level     = level_q;
  assign busy      = busy_q;
  assign pwm_out   = pwm_q;

endmodule

// File: tb/tb_rgb_seq_pwm.sv
// Directed and randomized bench for rgb_seq_pwm against a behavioural model
// built on a cycles-since-reset count and per-channel integer levels.
module tb_rgb_seq_pwm;
  localparam int N_CH = 3, DW = 8, N_COL = 7, TICK_DIV = 4, AUTO_STEPS = 2;
  localparam int AW = 3, PER = 255, EW = N_CH * DW;
  localparam logic [N_COL*EW-1:0] PAL = {24'h0A0B0C, 24'h808080, 24'h00FF00,
    24'hFF0080, 24'h203040, 24'h00527F, 24'h00007F};

  logic clk = 1'b0;
  logic rst, en, mode, dir, step, fade_en, wr_en;
  logic [AW-1:0] wr_addr;
  logic [EW-1:0] wr_data;
  logic [AW-1:0] color_idx;
  logic [EW-1:0] level;
  logic busy;
  logic [N_CH-1:0] pwm_out;

  rgb_seq_pwm #(.N_CH(N_CH), .DW(DW), .N_COL(N_COL), .TICK_DIV(TICK_DIV),
                .AUTO_STEPS(AUTO_STEPS), .PAL_INIT(PAL)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .dir(dir), .step(step),
    .fade_en(fade_en), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .color_idx(color_idx), .level(level), .busy(busy), .pwm_out(pwm_out));

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  string tag_s = "reset";

  // Reference model state
  int m_pal [N_COL][N_CH];
  int m_lvl [N_CH];
  int m_duty [N_CH];
  int m_idx, m_cyc, m_ticks;
  bit m_busy, m_stepq;
  logic [N_CH-1:0] m_pwm;
  logic [N_COL*EW-1:0] pal_v;

  task automatic model_reset();
    pal_v = PAL;
    for (int k = 0; k < N_COL; k++)
      for (int c = 0; c < N_CH; c++)
        m_pal[k][c] = int'(pal_v[(k*N_CH+c)*DW +: DW]);
    for (int c = 0; c < N_CH; c++) begin
      m_lvl[c]  = m_pal[0][c];
      m_duty[c] = m_pal[0][c];
    end
    m_idx = 0; m_cyc = 0; m_ticks = 0; m_busy = 0; m_stepq = 0; m_pwm = '0;
  endtask

  task automatic model_edge();
    int tgt [N_CH];
    bit tick, adv;
    int ph;
    if (rst) begin
      model_reset();
    end else begin
      tick = (m_cyc % TICK_DIV) == (TICK_DIV - 1);
      ph = m_cyc % PER;
      m_busy = 0;
      for (int c = 0; c < N_CH; c++) begin
        tgt[c] = m_pal[m_idx][c];
        m_pwm[c] = en && (ph < m_duty[c]);
        if (ph == PER - 1) m_duty[c] = m_lvl[c];
        if (m_lvl[c] != tgt[c]) m_busy = 1;
        if (!fade_en) m_lvl[c] = tgt[c];
        else if (tick && m_lvl[c] < tgt[c]) m_lvl[c] = m_lvl[c] + 1;
        else if (tick && m_lvl[c] > tgt[c]) m_lvl[c] = m_lvl[c] - 1;
      end
      if (en && mode) begin
        if (tick) m_ticks = m_ticks + 1;
        adv = tick && (m_ticks % AUTO_STEPS == 0);
      end else begin
        m_ticks = 0;
        adv = en && step && !m_stepq;
      end
      if (wr_en && int'(wr_addr) < N_COL)
        for (int c = 0; c < N_CH; c++)
          m_pal[wr_addr][c] = int'((wr_data >> (c*DW)) & 24'h0000FF);
      if (adv) m_idx = dir ? (m_idx + N_COL - 1) % N_COL : (m_idx + 1) % N_COL;
      m_stepq = step;
      m_cyc = m_cyc + 1;
    end
  endtask

  task automatic check();
    logic [EW-1:0] exp_lvl;
    for (int c = 0; c < N_CH; c++) exp_lvl[c*DW +: DW] = DW'(m_lvl[c]);
    n_vec++;
    assert (color_idx === AW'(m_idx)) else begin
      n_err++; $error("FAIL %s color_idx: got %0d expected %0d", tag_s, color_idx, m_idx);
    end
    n_vec++;
    assert (level === exp_lvl) else begin
      n_err++; $error("FAIL %s level: got %h expected %h", tag_s, level, exp_lvl);
    end
    n_vec++;
    assert (busy === m_busy) else begin
      n_err++; $error("FAIL %s busy: got %b expected %b", tag_s, busy, m_busy);
    end
    n_vec++;
    assert (pwm_out === m_pwm) else begin
      n_err++; $error("FAIL %s pwm_out: got %b expected %b", tag_s, pwm_out, m_pwm);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    #1;
    check();
  endtask

  task automatic pulse();
    step = 1'b1; cyc();
    step = 1'b0; cyc();
  endtask

  task automatic expect_int(string name, int got, int exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++; $error("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial begin
    int hi0, hi12, n, v0, nchg, last_chg, prev_idx;
    int seq [7] = '{1, 2, 3, 4, 5, 6, 0};
    rst = 1'b1; en = 1'b1; mode = 1'b0; dir = 1'b0; step = 1'b0;
    fade_en = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    for (int i = 0; i < 3; i++) cyc();
    expect_int("reset_idx", int'(color_idx), 0);
    expect_int("reset_pwm", int'(pwm_out), 0);
    rst = 1'b0;

    tag_s = "reset_pwm_period";
    hi0 = 0; hi12 = 0;
    for (int i = 0; i < PER; i++) begin
      cyc();
      hi0 += int'(pwm_out[0]);
      hi12 += int'(pwm_out[1] | pwm_out[2]);
    end
    expect_int("ch0_high_count", hi0, 127);
    expect_int("ch12_high_count", hi12, 0);

    tag_s = "manual_wrap";
    for (int k = 0; k < 7; k++) begin
      pulse();
      expect_int("fwd_seq", int'(color_idx), seq[k]);
    end
    dir = 1'b1;
    pulse();
    expect_int("back_wrap", int'(color_idx), 6);
    step = 1'b1;
    for (int i = 0; i < 50; i++) cyc();
    step = 1'b0; cyc();
    expect_int("held_step_once", int'(color_idx), 5);

    tag_s = "fade";
    dir = 1'b0;
    for (int i = 0; i < N_COL && m_idx != 0; i++) pulse();
    fade_en = 1'b1;
    step = 1'b1; cyc(); n = 1;
    step = 1'b0;
    while (level[15:8] !== 8'h52 && n < 400) begin cyc(); n++; end
    n_vec++;
    assert (n >= 325 && n <= 330) else begin
      n_err++; $error("FAIL fade_duration: got %0d cycles expected 325..330", n);
    end
    expect_int("busy_at_arrival", int'(busy), 1);
    cyc();
    expect_int("busy_after_arrival", int'(busy), 0);
    fade_en = 1'b0; dir = 1'b1; pulse();
    fade_en = 1'b1; dir = 1'b0; pulse();
    for (int i = 0; i < 120; i++) cyc();
    v0 = m_lvl[1];
    dir = 1'b1; pulse();
    for (int i = 0; i < 10; i++) cyc();
    n_vec++;
    assert (int'(level[15:8]) < v0 && int'(level[15:8]) >= v0 - 3) else begin
      n_err++; $error("FAIL fade_reverse: got %0d expected %0d..%0d", level[15:8], v0 - 3, v0 - 1);
    end
    fade_en = 1'b0; cyc();
    expect_int("fade_off_snap", int'(level), 24'h00007F);

    tag_s = "auto";
    mode = 1'b1; nchg = 0; last_chg = -1; prev_idx = m_idx;
    for (int i = 0; i < 80; i++) begin
      step = 1'($urandom_range(0, 1));
      cyc();
      if (int'(color_idx) != prev_idx) begin
        if (last_chg >= 0) expect_int("auto_interval", i - last_chg, 8);
        last_chg = i; nchg++; prev_idx = int'(color_idx);
      end
    end
    n_vec++;
    assert (nchg >= 9 && nchg <= 10) else begin
      n_err++; $error("FAIL auto_count: got %0d expected 9..10", nchg);
    end
    en = 1'b0; v0 = m_idx;
    for (int i = 0; i < 30; i++) cyc();
    expect_int("en0_idx_frozen", int'(color_idx), v0);
    expect_int("en0_pwm_zero", int'(pwm_out), 0);
    en = 1'b1; mode = 1'b0; step = 1'b0; cyc();

    tag_s = "duty_bounds";
    for (int i = 0; i < PER && (m_cyc % PER) != 100; i++) cyc();
    wr_en = 1'b1; wr_addr = AW'(m_idx); wr_data = 24'h0000FF; cyc();
    wr_en = 1'b0;
    for (int i = 0; i < 300; i++) cyc();
    hi0 = 0;
    for (int i = 0; i < PER; i++) begin cyc(); hi0 += int'(pwm_out[0]); end
    expect_int("duty_full", hi0, 255);
    wr_en = 1'b1; wr_addr = AW'(m_idx); wr_data = 24'h000000; cyc();
    wr_en = 1'b0;
    for (int i = 0; i < 300; i++) cyc();
    hi0 = 0;
    for (int i = 0; i < PER; i++) begin cyc(); hi0 += int'(pwm_out[0]); end
    expect_int("duty_zero", hi0, 0);

    tag_s = "simultaneous";
    dir = 1'b0;
    for (int i = 0; i < N_COL && m_idx != 2; i++) pulse();
    wr_en = 1'b1; wr_addr = 3'd3; wr_data = 24'h5A3C1E; step = 1'b1; cyc();
    wr_en = 1'b0; step = 1'b0; cyc();
    expect_int("wr_adv_level", int'(level), 24'h5A3C1E);
    expect_int("wr_adv_idx", int'(color_idx), 3);
    wr_en = 1'b1; wr_addr = 3'd7; wr_data = 24'h123456; cyc();
    wr_en = 1'b0;
    fade_en = 1'b1; pulse();
    for (int i = 0; i < 20; i++) cyc();
    rst = 1'b1; cyc();
    expect_int("rst_mid_fade_level", int'(level), 24'h00007F);
    expect_int("rst_mid_fade_busy", int'(busy), 0);
    rst = 1'b0;

    tag_s = "random";
    for (int i = 0; i < 2000; i++) begin
      en = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 49) == 0) mode = ~mode;
      if ($urandom_range(0, 99) == 0) fade_en = ~fade_en;
      dir = 1'($urandom_range(0, 1));
      step = ($urandom_range(0, 3) == 0);
      wr_en = ($urandom_range(0, 15) == 0);
      wr_addr = AW'($urandom_range(0, 7));
      wr_data = EW'($urandom);
      rst = ($urandom_range(0, 299) == 0);
      cyc();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
